rot_ctrl: RTL and testbench

ROT_CTRL -- requirements
Module: rot_ctrl

---
 rtl/rot_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_rot_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/rot_ctrl.sv
// ---------------------------------------------------------------------------
// rot_ctrl -- inter-stage twiddle rotation controller for a 16-point FFT.
//
// Tags every accepted sample with its position n in a 16-sample frame,
// derives the twiddle exponent e for the configured FFT stage, and presents
// the sample plus the ROM twiddle to an external combinational rotator.
// Twiddles that are trivial (e=0 -> multiply by 1, e=4 -> multiply by -j)
// are handled locally, and the external product is used otherwise.
// The data path is a two-register pipeline (operand register A, output
// register B) with valid/ready flow control at both ends.
//
// Ports
//   clk                 clock, rising edge
//   rst_n               asynchronous active-low reset
//   in_valid/in_ready   input handshake
//   in_sop              first sample of a frame (qualified by the transfer)
//   in_r/in_i           input sample, two's complement
//   out_valid/out_ready output handshake
//   out_sop             marks the output sample tagged n=0
//   out_r/out_i         rotated sample
//   rot_ip_r/rot_ip_i   sample operand to the external rotator
//   rot_w_r/rot_w_i     twiddle operand to the external rotator, Q(DATA_WIDTH-2)
//   rot_out_r/rot_out_i product returned by the external rotator
//   sync_err            one-cycle pulse when in_sop arrives mid-frame
// ---------------------------------------------------------------------------
module rot_ctrl #(
    parameter int DATA_WIDTH = 12,
    parameter int STAGE      = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sop,
    input  logic [DATA_WIDTH-1:0] in_r,
    input  logic [DATA_WIDTH-1:0] in_i,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sop,
    output logic [DATA_WIDTH-1:0] out_r,
    output logic [DATA_WIDTH-1:0] out_i,
    output logic [DATA_WIDTH-1:0] rot_ip_r,
    output logic [DATA_WIDTH-1:0] rot_ip_i,
    output logic [DATA_WIDTH-1:0] rot_w_r,
    output logic [DATA_WIDTH-1:0] rot_w_i,
    input  logic [DATA_WIDTH-1:0] rot_out_r,
    input  logic [DATA_WIDTH-1:0] rot_out_i,
    output logic                  sync_err
);

    // Twiddle group size, half-group and exponent scale for this stage
    localparam int G  = 16 >> (STAGE - 1);
    localparam int H  = G / 2;
    localparam int SH = STAGE - 1;
    // Fraction bits of the twiddle format
    localparam int FR = DATA_WIDTH - 2;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_NEGJ   = 2'd1,
        MODE_ROT    = 2'd2
    } mode_t;

    // Rounded magnitude of cos(k*pi/8) * 2^FR for k = 0..4.
    // Constants are cos values scaled by 2^30; rounding is half-up on the
    // magnitude so positive and negative table entries stay symmetric.
    function automatic logic [DATA_WIDTH-1:0] cos_mag(input logic [2:0] k);
        logic [63:0] c;
        case (k)
            3'd0:    c = 64'd1073741824;
            3'd1:    c = 64'd992008094;
            3'd2:    c = 64'd759250125;
            3'd3:    c = 64'd410903207;
            default: c = 64'd0;
        endcase
        return DATA_WIDTH'((c + (64'd1 << (29 - FR))) >> (30 - FR));
    endfunction

    // Real twiddle part: cos(2*pi*e/16)
    function automatic logic [DATA_WIDTH-1:0] tw_r(input logic [2:0] e);
        case (e)
            3'd0:    return cos_mag(3'd0);
            3'd1:    return cos_mag(3'd1);
            3'd2:    return cos_mag(3'd2);
            3'd3:    return cos_mag(3'd3);
            3'd4:    return cos_mag(3'd4);
            3'd5:    return -cos_mag(3'd3);
            3'd6:    return -cos_mag(3'd2);
            3'd7:    return -cos_mag(3'd1);
            default: return cos_mag(3'd0);
        endcase
    endfunction

    // Imaginary twiddle part: -sin(2*pi*e/16) = -cos(pi*|e-4|/8)
    function automatic logic [DATA_WIDTH-1:0] tw_i(input logic [2:0] e);
        case (e)
            3'd0:    return -cos_mag(3'd4);
            3'd1:    return -cos_mag(3'd3);
            3'd2:    return -cos_mag(3'd2);
            3'd3:    return -cos_mag(3'd1);
            3'd4:    return -cos_mag(3'd0);
            3'd5:    return -cos_mag(3'd1);
            3'd6:    return -cos_mag(3'd2);
            3'd7:    return -cos_mag(3'd3);
            default: return -cos_mag(3'd4);
        endcase
    endfunction

    // Two's complement negation clamped so the most negative value maps to
    // the most positive one instead of wrapping onto itself.
    function automatic logic [DATA_WIDTH-1:0] sat_neg(input logic [DATA_WIDTH-1:0] x);
        if (x == {1'b1, {(DATA_WIDTH-1){1'b0}}}) begin
            return {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else begin
            return -x;
        end
    endfunction

    logic [3:0] cnt_r;
    logic       a_vld_r;
    logic       a_sop_r;
    mode_t      a_mode_r;

    logic                  b_adv_s;
    logic                  in_xfer_s;
    logic [3:0]            n_tag_s;
    logic [3:0]            m_val_s;
    logic [3:0]            m_diff_s;
    logic [2:0]            e_val_s;
    mode_t                 mode_sel_s;
    logic [DATA_WIDTH-1:0] b_r_s;
    logic [DATA_WIDTH-1:0] b_i_s;

    // Handshake: B can take new data when empty or draining; A when empty or moving to B
    always_comb begin
        b_adv_s   = !out_valid || out_ready;
        in_ready  = !a_vld_r || b_adv_s;
        in_xfer_s = in_valid && in_ready;
    end

    // Sample tag, twiddle exponent and processing mode of the incoming sample
    always_comb begin
        n_tag_s  = in_sop ? 4'd0 : cnt_r;
        m_val_s  = n_tag_s & 4'(G - 1);
        m_diff_s = m_val_s - 4'(H);
        if (m_val_s >= 4'(H)) begin
            e_val_s = 3'(m_diff_s << SH);
        end else begin
            e_val_s = 3'd0;
        end
        case (e_val_s)
            3'd0:    mode_sel_s = MODE_BYPASS;
            3'd4:    mode_sel_s = MODE_NEGJ;
            default: mode_sel_s = MODE_ROT;
        endcase
    end

    // Result selected from the operand register for the output stage
    always_comb begin
        case (a_mode_r)
            MODE_BYPASS: begin
                b_r_s = rot_ip_r;
                b_i_s = rot_ip_i;
            end
            MODE_NEGJ: begin
                b_r_s = rot_ip_i;
                b_i_s = sat_neg(rot_ip_r);
            end
            MODE_ROT: begin
                b_r_s = rot_out_r;
                b_i_s = rot_out_i;
            end
            default: begin
                b_r_s = rot_ip_r;
                b_i_s = rot_ip_i;
            end
        endcase
    end

    // Frame sample counter and misaligned-sop detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r    <= 4'd0;
            sync_err <= 1'b0;
        end else begin
            sync_err <= in_xfer_s && in_sop && (cnt_r != 4'd0);
            if (in_xfer_s) begin
                cnt_r <= n_tag_s + 4'd1;
            end
        end
    end

    // Stage A: operand register feeding the external rotator.
    // Operands change only on a new transfer, so they stay stable while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_vld_r  <= 1'b0;
            a_sop_r  <= 1'b0;
            a_mode_r <= MODE_BYPASS;
            rot_ip_r <= '0;
            rot_ip_i <= '0;
            rot_w_r  <= '0;
            rot_w_i  <= '0;
        end else begin
            a_vld_r <= in_xfer_s || (a_vld_r && !b_adv_s);
            if (in_xfer_s) begin
                a_sop_r  <= (n_tag_s == 4'd0);
                a_mode_r <= mode_sel_s;
                rot_ip_r <= in_r;
                rot_ip_i <= in_i;
                rot_w_r  <= tw_r(e_val_s);
                rot_w_i  <= tw_i(e_val_s);
            end
        end
    end

    // Stage B: output register, loads whenever it is empty or being drained
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_r     <= '0;
            out_i     <= '0;
        end else if (b_adv_s) begin
            out_valid <= a_vld_r;
            if (a_vld_r) begin
                out_sop <= a_sop_r;
                out_r   <= b_r_s;
                out_i   <= b_i_s;
            end
        end
    end

endmodule

// File: tb/tb_rot_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rot_ctrl -- directed self-checking bench for rot_ctrl.
// Two instances share one input stream: dut1 at STAGE=1, dut2 at STAGE=2,
// both DATA_WIDTH=12. The external rotator is modelled here as a truncating
// complex multiply by a Q10 twiddle.
// ---------------------------------------------------------------------------
module tb_rot_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid, in_sop, out_ready;
    logic signed [11:0] in_r, in_i;

    logic d1_in_ready, d1_out_valid, d1_out_sop, d1_sync_err;
    logic signed [11:0] d1_out_r, d1_out_i, d1_ip_r, d1_ip_i, d1_w_r, d1_w_i, d1_rot_r, d1_rot_i;
    logic d2_in_ready, d2_out_valid, d2_out_sop, d2_sync_err;
    logic signed [11:0] d2_out_r, d2_out_i, d2_ip_r, d2_ip_i, d2_w_r, d2_w_i, d2_rot_r, d2_rot_i;
    logic signed [31:0] p1r, p1i, p2r, p2i;

    int n_cmp = 0;
    int n_bad = 0;

    int WR [8] = '{1024, 946, 724, 392, 0, -392, -724, -946};
    int WI [8] = '{0, -392, -724, -946, -1024, -946, -724, -392};
    int E1 [16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 3, 4, 5, 6, 7};
    int E2 [16] = '{0, 0, 0, 0, 0, 2, 4, 6, 0, 0, 0, 0, 0, 2, 4, 6};

    always #5 clk = ~clk;

    // External rotator models
    assign p1r = d1_ip_r * d1_w_r - d1_ip_i * d1_w_i;
    assign p1i = d1_ip_r * d1_w_i + d1_ip_i * d1_w_r;
    assign p2r = d2_ip_r * d2_w_r - d2_ip_i * d2_w_i;
    assign p2i = d2_ip_r * d2_w_i + d2_ip_i * d2_w_r;
    assign d1_rot_r = p1r[21:10];
    assign d1_rot_i = p1i[21:10];
    assign d2_rot_r = p2r[21:10];
    assign d2_rot_i = p2i[21:10];

    rot_ctrl #(.DATA_WIDTH(12), .STAGE(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(d1_in_ready), .in_sop(in_sop),
        .in_r(in_r), .in_i(in_i),
        .out_valid(d1_out_valid), .out_ready(out_ready), .out_sop(d1_out_sop),
        .out_r(d1_out_r), .out_i(d1_out_i),
        .rot_ip_r(d1_ip_r), .rot_ip_i(d1_ip_i), .rot_w_r(d1_w_r), .rot_w_i(d1_w_i),
        .rot_out_r(d1_rot_r), .rot_out_i(d1_rot_i),
        .sync_err(d1_sync_err)
    );

    rot_ctrl #(.DATA_WIDTH(12), .STAGE(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(d2_in_ready), .in_sop(in_sop),
        .in_r(in_r), .in_i(in_i),
        .out_valid(d2_out_valid), .out_ready(out_ready), .out_sop(d2_out_sop),
        .out_r(d2_out_r), .out_i(d2_out_i),
        .rot_ip_r(d2_ip_r), .rot_ip_i(d2_ip_i), .rot_w_r(d2_w_r), .rot_w_i(d2_w_i),
        .rot_out_r(d2_rot_r), .rot_out_i(d2_rot_i),
        .sync_err(d2_sync_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input int r, input int i);
        in_valid = v;
        in_sop   = s;
        in_r     = 12'(r);
        in_i     = 12'(i);
        step();
    endtask

    task automatic test_reset();
        in_valid = 1'b0; in_sop = 1'b0; in_r = '0; in_i = '0; out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (d1_out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got %0b want 0", d1_out_valid); end
        n_cmp++; if (d1_in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready got %0b want 1", d1_in_ready); end
        n_cmp++; if (d1_ip_r !== 12'sd0 || d1_w_r !== 12'sd0 || d1_w_i !== 12'sd0) begin n_bad++; $display("FAIL rst_rot got ip=%0d w=(%0d,%0d) want 0", d1_ip_r, d1_w_r, d1_w_i); end
        n_cmp++; if (d1_out_r !== 12'sd0 || d1_out_sop !== 1'b0 || d1_sync_err !== 1'b0) begin n_bad++; $display("FAIL rst_out got r=%0d sop=%0b err=%0b want 0", d1_out_r, d1_out_sop, d1_sync_err); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_cmp++; if (d2_out_valid !== 1'b0 || d2_in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release got v=%0b rdy=%0b want 0/1", d2_out_valid, d2_in_ready); end
    endtask

    task automatic test_frame();
        int k, e, er, ei;
        for (int t = 0; t <= 16; t++) begin
            if (t < 16) drive(1'b1, t == 0, 512, 0);
            else        drive(1'b0, 1'b0, 0, 0);
            if (t == 9) begin
                n_cmp++; if (d1_w_r !== 12'sd946 || d1_w_i !== -12'sd392) begin n_bad++; $display("FAIL frame_w9 got (%0d,%0d) want (946,-392)", d1_w_r, d1_w_i); end
            end
            if (t == 10) begin
                n_cmp++; if (d2_w_r !== 12'sd1024 || d2_w_i !== 12'sd0) begin n_bad++; $display("FAIL s2_w10 got (%0d,%0d) want (1024,0)", d2_w_r, d2_w_i); end
            end
            if (t == 13) begin
                n_cmp++; if (d2_w_r !== 12'sd724 || d2_w_i !== -12'sd724) begin n_bad++; $display("FAIL s2_w13 got (%0d,%0d) want (724,-724)", d2_w_r, d2_w_i); end
            end
            n_cmp++; if (d1_in_ready !== 1'b1 || d1_sync_err !== 1'b0) begin n_bad++; $display("FAIL frame_rdy t=%0d got rdy=%0b err=%0b want 1/0", t, d1_in_ready, d1_sync_err); end
            if (t == 0) begin
                n_cmp++; if (d1_out_valid !== 1'b0) begin n_bad++; $display("FAIL frame_latency got out_valid=%0b want 0", d1_out_valid); end
            end else begin
                k = t - 1;
                e = E1[k];
                if (e == 0)      begin er = 512;       ei = 0;         end
                else if (e == 4) begin er = 0;         ei = -512;      end
                else             begin er = WR[e] / 2; ei = WI[e] / 2; end
                n_cmp++; if (d1_out_valid !== 1'b1 || d1_out_sop !== (k == 0) || d1_out_r !== er || d1_out_i !== ei)
                    begin n_bad++; $display("FAIL s1_out n=%0d got v=%0b sop=%0b (%0d,%0d) want 1/%0b (%0d,%0d)", k, d1_out_valid, d1_out_sop, d1_out_r, d1_out_i, k == 0, er, ei); end
                e = E2[k];
                if (e == 0)      begin er = 512;       ei = 0;         end
                else if (e == 4) begin er = 0;         ei = -512;      end
                else             begin er = WR[e] / 2; ei = WI[e] / 2; end
                n_cmp++; if (d2_out_valid !== 1'b1 || d2_out_r !== er || d2_out_i !== ei)
                    begin n_bad++; $display("FAIL s2_out n=%0d got v=%0b (%0d,%0d) want 1 (%0d,%0d)", k, d2_out_valid, d2_out_r, d2_out_i, er, ei); end
            end
        end
        step();
        n_cmp++; if (d1_out_valid !== 1'b0) begin n_bad++; $display("FAIL frame_drain got out_valid=%0b want 0", d1_out_valid); end
    endtask

    task automatic test_saturate();
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, k == 0, (k == 12) ? -2048 : 0, (k == 12) ? 5 : 0);
            if (k == 13) begin
                n_cmp++; if (d1_out_r !== 12'sd5 || d1_out_i !== 12'sd2047) begin n_bad++; $display("FAIL sat_negj got (%0d,%0d) want (5,2047)", d1_out_r, d1_out_i); end
                n_cmp++; if (d2_out_r !== -12'sd2048 || d2_out_i !== 12'sd5) begin n_bad++; $display("FAIL sat_bypass got (%0d,%0d) want (-2048,5)", d2_out_r, d2_out_i); end
            end
        end
        drive(1'b0, 1'b0, 0, 0);
        step();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 100, 50);
        n_cmp++; if (d1_in_ready !== 1'b1 || d1_out_valid !== 1'b0) begin n_bad++; $display("FAIL stall_first got rdy=%0b v=%0b want 1/0", d1_in_ready, d1_out_valid); end
        drive(1'b1, 1'b0, 101, 51);
        n_cmp++; if (d1_in_ready !== 1'b0 || d1_out_valid !== 1'b1 || d1_out_r !== 12'sd100) begin n_bad++; $display("FAIL stall_second got rdy=%0b v=%0b r=%0d want 0/1/100", d1_in_ready, d1_out_valid, d1_out_r); end
        drive(1'b1, 1'b0, 102, 52);
        n_cmp++; if (d1_in_ready !== 1'b0 || d1_out_r !== 12'sd100 || d1_out_i !== 12'sd50 || d1_out_sop !== 1'b1)
            begin n_bad++; $display("FAIL stall_hold_out got rdy=%0b (%0d,%0d) sop=%0b want 0 (100,50) 1", d1_in_ready, d1_out_r, d1_out_i, d1_out_sop); end
        n_cmp++; if (d1_ip_r !== 12'sd101 || d1_w_r !== 12'sd1024) begin n_bad++; $display("FAIL stall_hold_rot got ip=%0d w=%0d want 101/1024", d1_ip_r, d1_w_r); end
        out_ready = 1'b1;
        step();
        n_cmp++; if (d1_out_valid !== 1'b1 || d1_out_r !== 12'sd101 || d1_out_sop !== 1'b0) begin n_bad++; $display("FAIL release_s1 got v=%0b r=%0d sop=%0b want 1/101/0", d1_out_valid, d1_out_r, d1_out_sop); end
        drive(1'b1, 1'b0, 103, 53);
        n_cmp++; if (d1_out_valid !== 1'b1 || d1_out_r !== 12'sd102 || d1_out_i !== 12'sd52) begin n_bad++; $display("FAIL release_s2 got v=%0b (%0d,%0d) want 1 (102,52)", d1_out_valid, d1_out_r, d1_out_i); end
        drive(1'b1, 1'b0, 104, 54);
        n_cmp++; if (d1_out_valid !== 1'b1 || d1_out_r !== 12'sd103) begin n_bad++; $display("FAIL release_s3 got v=%0b r=%0d want 1/103", d1_out_valid, d1_out_r); end
        drive(1'b0, 1'b0, 0, 0);
        n_cmp++; if (d1_out_valid !== 1'b1 || d1_out_r !== 12'sd104) begin n_bad++; $display("FAIL release_s4 got v=%0b r=%0d want 1/104", d1_out_valid, d1_out_r); end
        step();
        n_cmp++; if (d1_out_valid !== 1'b0) begin n_bad++; $display("FAIL release_end got v=%0b want 0", d1_out_valid); end
    endtask

    task automatic test_sync_err();
        drive(1'b1, 1'b1, 77, 33);
        n_cmp++; if (d1_sync_err !== 1'b1 || d2_sync_err !== 1'b1) begin n_bad++; $display("FAIL sync_pulse got %0b/%0b want 1/1", d1_sync_err, d2_sync_err); end
        drive(1'b0, 1'b0, 0, 0);
        n_cmp++; if (d1_sync_err !== 1'b0) begin n_bad++; $display("FAIL sync_width got %0b want 0", d1_sync_err); end
        n_cmp++; if (d1_out_valid !== 1'b1 || d1_out_sop !== 1'b1 || d1_out_r !== 12'sd77) begin n_bad++; $display("FAIL sync_tag got v=%0b sop=%0b r=%0d want 1/1/77", d1_out_valid, d1_out_sop, d1_out_r); end
        step();
    endtask

    task automatic test_reset_midframe();
        for (int k = 1; k <= 6; k++) drive(1'b1, 1'b0, 200 + k, 0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (d1_out_valid !== 1'b0 || d1_out_r !== 12'sd0 || d1_ip_r !== 12'sd0 || d2_w_r !== 12'sd0 || d1_in_ready !== 1'b1)
            begin n_bad++; $display("FAIL midrst_clear got v=%0b r=%0d ip=%0d w=%0d rdy=%0b want 0/0/0/0/1", d1_out_valid, d1_out_r, d1_ip_r, d2_w_r, d1_in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_cmp++; if (d1_out_valid !== 1'b0 || d2_out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_stale got %0b/%0b want 0/0", d1_out_valid, d2_out_valid); end
        drive(1'b1, 1'b0, 300, 10);
        n_cmp++; if (d2_w_r !== 12'sd1024 || d2_w_i !== 12'sd0) begin n_bad++; $display("FAIL midrst_n0 got w=(%0d,%0d) want (1024,0)", d2_w_r, d2_w_i); end
        drive(1'b0, 1'b0, 0, 0);
        n_cmp++; if (d2_out_valid !== 1'b1 || d2_out_r !== 12'sd300 || d2_out_i !== 12'sd10) begin n_bad++; $display("FAIL midrst_out got v=%0b (%0d,%0d) want 1 (300,10)", d2_out_valid, d2_out_r, d2_out_i); end
        for (int k = 1; k <= 5; k++) drive(1'b1, 1'b0, k, 0);
        n_cmp++; if (d2_w_r !== 12'sd724 || d2_w_i !== -12'sd724) begin n_bad++; $display("FAIL midrst_n5 got w=(%0d,%0d) want (724,-724)", d2_w_r, d2_w_i); end
        drive(1'b0, 1'b0, 0, 0);
        step();
    endtask

    initial begin
        test_reset();
        test_frame();
        test_saturate();
        test_back_to_back();
        test_sync_err();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
